// File: rtl/byte_serial_adder.sv
// Purpose : adds two NBYTES-wide operands one byte per cycle through an external 8-bit adder.
// Latency : NBYTES cycles in RUN, then a one-cycle DONE (done pulse); result valid from DONE onward.
// Backpr. : none; start is only sampled in IDLE, so requests during RUN/DONE are dropped.
// Ports   : clk/rst (async active-high); start, x1, x2, cin request an addition;
//           add_x1/add_x2/add_cin drive the external adder, add_sum/add_cout return from it;
//           sum/cout are the registered result, busy marks RUN, done marks completion.
module byte_serial_adder #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   x1,
    input  logic [8*NBYTES-1:0]   x2,
    input  logic                  cin,
    output logic [7:0]            add_x1,
    output logic [7:0]            add_x2,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  carry_q, carry_d;
    logic [8*NBYTES-1:0]   x1_q, x1_d;
    logic [8*NBYTES-1:0]   x2_q, x2_d;
    logic [8*NBYTES-1:0]   sum_q, sum_d;
    logic                  cout_q, cout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            x1_q    <= '0;
            x2_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        add_x1  = 8'd0;
        add_x2  = 8'd0;
        add_cin = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Operands are captured so later input changes cannot disturb the run.
                    x1_d    = x1;
                    x2_d    = x2;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                add_cin = carry_q;
                // Byte select/insert as a decoded loop keeps every slice constant-indexed.
                for (int b = 0; b < NBYTES; b++) begin
                    if (idx_q == IW'(b)) begin
                        add_x1           = x1_q[b*8 +: 8];
                        add_x2           = x2_q[b*8 +: 8];
                        sum_d[b*8 +: 8]  = add_sum;
                    end
                end
                carry_d = add_cout;
                // Index may wrap after the last byte; it is re-cleared on the next start.
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_byte_serial_adder.sv
module tb_byte_serial_adder;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;

    always #5 clk = ~clk;

    // 4-byte instance
    logic          start;
    logic [31:0]   x1, x2;
    logic          cin;
    logic [7:0]    ax1, ax2, asum;
    logic          acin, acout;
    logic [31:0]   sum;
    logic          cout, busy, done;

    // 1-byte instance
    logic          start_1;
    logic [7:0]    x1_1, x2_1;
    logic          cin_1;
    logic [7:0]    ax1_1, ax2_1, asum_1;
    logic          acin_1, acout_1;
    logic [7:0]    sum_1;
    logic          cout_1, busy_1, done_1;

    // Downstream ripple-carry adders
    assign {acout, asum}     = {1'b0, ax1}   + {1'b0, ax2}   + {8'b0, acin};
    assign {acout_1, asum_1} = {1'b0, ax1_1} + {1'b0, ax2_1} + {8'b0, acin_1};

    byte_serial_adder #(.NBYTES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .x1(x1), .x2(x2), .cin(cin),
        .add_x1(ax1), .add_x2(ax2), .add_cin(acin), .add_sum(asum), .add_cout(acout),
        .sum(sum), .cout(cout), .busy(busy), .done(done)
    );

    byte_serial_adder #(.NBYTES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_1), .x1(x1_1), .x2(x2_1), .cin(cin_1),
        .add_x1(ax1_1), .add_x2(ax2_1), .add_cin(acin_1), .add_sum(asum_1), .add_cout(acout_1),
        .sum(sum_1), .cout(cout_1), .busy(busy_1), .done(done_1)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Adder port must be quiet whenever the block is not running.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!busy)   chk("idle_add",   {47'b0, ax1, ax2, acin}, 64'd0);
            if (!busy_1) chk("idle_add_1", {47'b0, ax1_1, ax2_1, acin_1}, 64'd0);
        end
    end

    // One operation with the result predicted by plain arithmetic; operands are
    // scrambled during RUN to prove they were captured at acceptance.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic ci,
                          input bit chain, input int gap);
        logic [32:0] e;
        e = {1'b0, a} + {1'b0, b} + {32'b0, ci};
        for (int g = 0; g < gap; g++) @(negedge clk);
        @(negedge clk);
        x1 = a; x2 = b; cin = ci; start = 1'b1;
        for (int c = 1; c <= N + 1; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= N) begin
                chk("busy_run", busy, 1'b1);
                chk("done_early", done, 1'b0);
                chk("slice_x1", ax1, a[(c-1)*8 +: 8]);
                chk("slice_x2", ax2, b[(c-1)*8 +: 8]);
                if (chain) chk("chain_cin", acin, 1'b1);
            end else begin
                chk("busy_done", busy, 1'b0);
                chk("done_pulse", done, 1'b1);
                chk("sum", sum, e[31:0]);
                chk("cout", cout, e[32]);
            end
            x1 = $urandom; x2 = $urandom; cin = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("done_once", done, 1'b0);
        chk("sum_hold", sum, e[31:0]);
        chk("cout_hold", cout, e[32]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; x1 = '0; x2 = '0; cin = 1'b0;
        start_1 = 1'b0; x1_1 = '0; x2_1 = '0; cin_1 = 1'b0;
        #1;
        chk("rst_sum",  sum,  32'd0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Single-byte instance: FF + 01 + 1
        @(negedge clk);
        x1_1 = 8'hFF; x2_1 = 8'h01; cin_1 = 1'b1; start_1 = 1'b1;
        @(negedge clk);
        start_1 = 1'b0;
        chk("n1_busy", busy_1, 1'b1);
        chk("n1_done_early", done_1, 1'b0);
        @(negedge clk);
        chk("n1_done", done_1, 1'b1);
        chk("n1_sum", sum_1, 8'h01);
        chk("n1_cout", cout_1, 1'b1);
        @(negedge clk);
        chk("n1_done_once", done_1, 1'b0);

        // Directed cases
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0);
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 0);

        // Start held high throughout; operands change during RUN.
        @(negedge clk);
        x1 = 32'h12345678; x2 = 32'h87654321; cin = 1'b0; start = 1'b1;
        for (int c = 1; c <= N; c++) begin
            @(negedge clk);
            chk("hold_busy", busy, 1'b1);
            chk("hold_done_early", done, 1'b0);
            x1 = $urandom; x2 = $urandom; cin = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("hold_done", done, 1'b1);
        chk("hold_sum", sum, 32'h99999999);
        chk("hold_cout", cout, 1'b0);
        x1 = 32'h00000005; x2 = 32'h00000006; cin = 1'b1;
        @(negedge clk);
        chk("hold_idle_busy", busy, 1'b0);
        chk("hold_idle_done", done, 1'b0);
        @(negedge clk);
        chk("hold_restart", busy, 1'b1);
        start = 1'b0;
        for (int c = 2; c <= N; c++) @(negedge clk);
        @(negedge clk);
        chk("hold2_done", done, 1'b1);
        chk("hold2_sum", sum, 32'h0000000C);
        @(negedge clk);

        // Reset in the middle of an operation
        @(negedge clk);
        x1 = 32'hDEADBEEF; x2 = 32'h11111111; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_sum",  sum,  32'd0);
        chk("mid_rst_cout", cout, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_no_done", done, 1'b0);
        end
        rst = 1'b0;
        run_op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 0);

        // Randomized operations with random gaps
        for (int t = 0; t < 1000; t++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0,
                   int'($urandom_range(0, 3)));
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_serial_adder.md
BYTE_SERIAL_ADDER -- requirements
Module: byte_serial_adder

Interface
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the number of bytes per operand (legal values 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a new addition; sampled only in IDLE.
REQ-005 The block SHALL have ports x1 and x2, inputs, 8*NBYTES bits each: the operands.
REQ-006 The block SHALL have port cin, input, 1 bit: carry-in to byte 0.
REQ-007 The block SHALL have ports add_x1 and add_x2, outputs, 8 bits each: the current byte slice driven to the downstream 8-bit ripple-carry adder.
REQ-008 The block SHALL have port add_cin, output, 1 bit: carry driven to that adder.
REQ-009 The block SHALL have port add_sum, input, 8 bits: the adder's combinational sum, returned in the same cycle.
REQ-010 The block SHALL have port add_cout, input, 1 bit: the adder's combinational carry-out.
REQ-011 The block SHALL have port sum, output, 8*NBYTES bits: the registered full-width result.
REQ-012 The block SHALL have port cout, output, 1 bit: the registered final carry.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE with start=1 at edge k, the block SHALL latch x1, x2 and cin, clear the byte index to 0, clear the sum register, and enter RUN.
REQ-017 In RUN at byte index i, add_x1 and add_x2 SHALL carry byte i of the latched x1 and x2, and add_cin SHALL carry the carry register (the latched cin when i=0).
REQ-018 At each RUN edge, the block SHALL write add_sum into byte i of sum, load add_cout into the carry register, and increment i.
REQ-019 When i=NBYTES-1 is captured (edge k+NBYTES), the block SHALL load cout from add_cout and enter DONE.
REQ-020 done SHALL be high only in the cycle between edges k+NBYTES and k+NBYTES+1; DONE SHALL return to IDLE unconditionally.
REQ-021 busy SHALL be high only in RUN, i.e. for exactly NBYTES cycles per operation.
REQ-022 start SHALL be ignored in RUN and DONE, including start held high continuously; in that case the next operation is accepted on the first IDLE cycle.
REQ-023 Changes on x1, x2 or cin after acceptance SHALL NOT affect the operation in progress.
REQ-024 Outside RUN, add_x1, add_x2 and add_cin SHALL be driven to 0.
REQ-025 sum and cout SHALL hold their final values from DONE until the next accepted start; sum is partially updated during RUN.
REQ-026 The result SHALL equal (x1 + x2 + cin) mod 2^(8*NBYTES), and cout SHALL be the carry out of the top byte.

Reset
REQ-027 While rst=1, the block SHALL force state IDLE, index 0, carry register 0, sum=0, cout=0, busy=0 and done=0, independent of clk.
REQ-028 A reset during RUN or DONE SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be processed normally.

Verification
REQ-029 Scenario (NBYTES=4): x1=0x000000FF, x2=0x00000001, cin=0, start at edge k -> busy high for edges k..k+4, done high cycle k+4..k+5, sum=0x00000100, cout=0.
REQ-030 Scenario (full carry chain): x1=0xFFFFFFFF, x2=0x00000000, cin=1 -> sum=0x00000000, cout=1, and add_cin=1 in every RUN cycle.
REQ-031 Scenario (operand stability): x1=0x12345678, x2=0x87654321, cin=0, start held high and operands changed during RUN -> sum=0x99999999, cout=0, exactly one done pulse per accepted start, next operation begins on the first IDLE cycle.
REQ-032 Scenario (reset mid-operation): rst=1 at edge k+2 of an operation -> sum=0, cout=0, busy=0, no done; a following 0x00000001+0x00000001 operation gives sum=0x00000002.
REQ-033 Scenario (NBYTES=1): x1=0xFF, x2=0x01, cin=1 -> sum=0x01, cout=1, done in cycle k+1..k+2.
REQ-034 Scenario (randomized): 1000 random x1, x2, cin with start at random gaps -> every result matches the reference model, and add_x1/add_x2/add_cin are 0 whenever busy=0.
